// File: rtl/telemetry_pkg.sv
// Shared constants and helpers for the telemetry link (frame header, payload size,
// parser state encodings and default line timing).
package telemetry_pkg;

    localparam logic [7:0] HDR0 = 8'hDE;
    localparam logic [7:0] HDR1 = 8'hAD;
    localparam int PAYLOAD_BYTES = 6;

    // 10 MHz / 9600 baud, and roughly two byte-times of allowed idle inside a frame
    localparam int DEFAULT_BAUD_DIV       = 1041;
    localparam int DEFAULT_TIMEOUT_CYCLES = 20820;

    // Frame parser state encodings
    localparam logic [1:0] P_HUNT_DE = 2'd0;
    localparam logic [1:0] P_HUNT_AD = 2'd1;
    localparam logic [1:0] P_PAYLOAD = 2'd2;

    typedef struct packed {
        logic signed [15:0] roll;
        logic signed [15:0] pitch;
        logic signed [15:0] yaw;
    } attitude_t;

    // Split a 48-bit big-endian payload into the three angle words
    function automatic attitude_t unpack_frame(input logic [47:0] frame);
        attitude_t att;
        att.roll  = frame[47:32];
        att.pitch = frame[31:16];
        att.yaw   = frame[15:0];
        return att;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 byte receiver: 2-flop synchroniser, start-bit qualification at mid-bit,
// LSB-first data sampling and stop-bit check. Emits one-cycle valid / framing-error pulses.
module uart_rx
    import telemetry_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       byte_ferr
);

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_START = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;
    localparam logic [1:0] R_STOP  = 2'd3;

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);

    logic             sync1_q, sync2_q, prev_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    // Synchronise the asynchronous line and keep one cycle of history for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Bit-timing FSM: each sample point is reached when the cycle counter hits its limit
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            R_IDLE: begin
                if (prev_q && !sync2_q) begin
                    state_d = R_START;
                    cnt_d   = '0;
                end else begin
                    state_d = R_IDLE;
                end
            end
            R_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    bit_d = 3'd0;
                    // A line that is already high again at mid-start was only a glitch
                    if (sync2_q) begin
                        state_d = R_IDLE;
                    end else begin
                        state_d = R_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            R_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = R_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            R_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = R_IDLE;
                    if (sync2_q) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = R_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Receiver state and registered byte outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= R_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign data       = data_q;
    assign byte_valid = valid_q;
    assign byte_ferr  = ferr_q;

endmodule

// File: rtl/telemetry_uart_rx.sv
// Telemetry link receiver: locks onto "DE AD" framed 6-byte attitude payloads and
// publishes roll/pitch/yaw atomically, discarding frames on framing error or timeout.
module telemetry_uart_rx
    import telemetry_pkg::*;
#(
    parameter int BAUD_DIV       = DEFAULT_BAUD_DIV,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx,
    output logic signed [15:0] roll,
    output logic signed [15:0] pitch,
    output logic signed [15:0] yaw,
    output logic               frame_valid,
    output logic               frame_err
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST     = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]       PAYLOAD_LAST = 3'(PAYLOAD_BYTES - 1);

    logic [7:0]       rx_data_s;
    logic             rx_valid_s;
    logic             rx_ferr_s;

    logic [1:0]       state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    // Holds the first five payload bytes; the sixth is merged in on the commit cycle
    logic [39:0]      shadow_q, shadow_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    attitude_t        att_q, att_d;
    logic             fv_q, fv_d;
    logic             fe_q, fe_d;

    uart_rx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .data       (rx_data_s),
        .byte_valid (rx_valid_s),
        .byte_ferr  (rx_ferr_s)
    );

    // Frame parser: header hunt, payload collection, error and idle-timeout discard
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        tmo_d    = tmo_q;
        att_d    = att_q;
        fv_d     = 1'b0;
        fe_d     = 1'b0;
        if (rx_ferr_s) begin
            // Only a frame already under way counts as discarded
            fe_d    = (state_q != P_HUNT_DE);
            state_d = P_HUNT_DE;
            idx_d   = 3'd0;
            tmo_d   = '0;
        end else if (rx_valid_s) begin
            // A byte arriving in the same cycle as the timeout takes priority
            tmo_d = '0;
            case (state_q)
                P_HUNT_DE: begin
                    if (rx_data_s == HDR0) begin
                        state_d = P_HUNT_AD;
                    end else begin
                        state_d = P_HUNT_DE;
                    end
                end
                P_HUNT_AD: begin
                    if (rx_data_s == HDR1) begin
                        state_d = P_PAYLOAD;
                        idx_d   = 3'd0;
                    end else if (rx_data_s == HDR0) begin
                        state_d = P_HUNT_AD;
                    end else begin
                        state_d = P_HUNT_DE;
                    end
                end
                P_PAYLOAD: begin
                    shadow_d = {shadow_q[31:0], rx_data_s};
                    if (idx_q == PAYLOAD_LAST) begin
                        att_d   = unpack_frame({shadow_q, rx_data_s});
                        fv_d    = 1'b1;
                        state_d = P_HUNT_DE;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
                default: begin
                    state_d = P_HUNT_DE;
                    idx_d   = 3'd0;
                end
            endcase
        end else if (state_q == P_HUNT_DE) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
            fe_d    = 1'b1;
            state_d = P_HUNT_DE;
            idx_d   = 3'd0;
            tmo_d   = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    // Parser state, timeout counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= P_HUNT_DE;
            idx_q    <= 3'd0;
            shadow_q <= 40'd0;
            tmo_q    <= '0;
            att_q    <= '0;
            fv_q     <= 1'b0;
            fe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            tmo_q    <= tmo_d;
            att_q    <= att_d;
            fv_q     <= fv_d;
            fe_q     <= fe_d;
        end
    end

    assign roll        = att_q.roll;
    assign pitch       = att_q.pitch;
    assign yaw         = att_q.yaw;
    assign frame_valid = fv_q;
    assign frame_err   = fe_q;

endmodule
